pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised, elastic pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle under a valid/ready handshake.
- Provides stall (freeze), synchronous flush (bubble insertion) and an optional 1-entry skid buffer, so in_ready_o has no combinational path from out_ready_i.
- Control outputs read as all-zero (NOP) whenever the stage holds no valid entry.

Parameters:
- DATA_W, 128: width of the data bundle (pc, data1, data2, immediate, instruction concatenated).
- CTRL_W, 9: width of the control bundle (RegDst, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, ExtOp, ALUOp[1:0]).
- SKID, 1: 1 = two-entry skid mode; 0 = single-register mode.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  freeze stage: no accept, no release
- flush_i  in  1  synchronous discard of all held entries
- in_valid_i  in  1  upstream entry valid
- in_ready_o  out  1  stage can accept this cycle
- in_data_i  in  DATA_W  upstream data bundle
- in_ctrl_i  in  CTRL_W  upstream control bundle
- out_valid_o  out  1  output entry valid
- out_ready_i  in  1  downstream accepts
- out_data_o  out  DATA_W  output data bundle
- out_ctrl_o  out  CTRL_W  output control bundle, zero when not valid
- occupancy_o  out  2  entries held (0..2)

Behaviour:
- Storage: main entry (main_valid, main_data, main_ctrl) drives the outputs; skid entry (skid_valid, skid_data, skid_ctrl) exists only when SKID=1.
- Reset (rst_i low, async):
  - main_valid, skid_valid, all data and ctrl registers = 0.
  - Outputs after reset: out_valid_o=0, out_ctrl_o=0, out_data_o=0, occupancy_o=0, in_ready_o=1 (provided stall_i=0 and flush_i=0).
- Handshake equations:
  - out_valid_o = main_valid & !stall_i.
  - deq = out_valid_o & out_ready_i.
  - SKID=1: in_ready_o = !skid_valid & !stall_i & !flush_i. Registered state only; no out_ready_i term.
  - SKID=0: in_ready_o = (!main_valid | out_ready_i) & !stall_i & !flush_i.
  - enq = in_valid_i & in_ready_o.
- States, encoded by occupancy: EMPTY(0), ONE(1), FULL(2). FULL is reachable only when SKID=1. Next state is registered on the rising edge of clk_i:
  - EMPTY, enq: input loads main -> ONE.
  - ONE, enq & deq: input loads main -> ONE.
  - ONE, deq & !enq: main_valid cleared -> EMPTY.
  - ONE, enq & !deq: SKID=1, input loads skid -> FULL. Unreachable when SKID=0, because in_ready_o requires out_ready_i.
  - FULL, deq: skid moves to main, skid_valid cleared -> ONE. No enq is possible.
  - Otherwise: hold.
- Ordering is strictly FIFO; no entry is duplicated or dropped except by flush.
- Flush (flush_i high at a clock edge):
  - main_valid and skid_valid -> 0; data registers hold their values.
  - in_ready_o is low, so no input is lost.
  - Flush takes priority over stall and over deq: with flush and out_ready_i high in the same cycle, the output handshake still completes, so the downstream stage decides whether to ignore it.
- Stall: all state holds; in_ready_o=0; out_valid_o=0; out_data_o holds; out_ctrl_o=0.
- Output masking:
  - out_ctrl_o = main_valid & !stall_i ? main_ctrl : 0 (combinational mask).
  - out_data_o = main_data, never masked.
- occupancy_o = main_valid + skid_valid.
- Reset mid-operation discards all entries immediately.
- Latency: one cycle from enq to out_valid_o; throughput one entry per cycle in both modes.

Decomposition:
- Shared package pipe_pkg holds:
  - constants ID_EX_CTRL_W=9 and ID_EX_DATA_W=128;
  - bit-position constants for each control field;
  - packed typedef id_ex_ctrl_t.
- No sub-module; the skid entry is two registers plus a mux inside this block.

Test Plan:
- Reset then idle: rst_i low during active traffic -> out_valid_o=0, out_ctrl_o=0, occupancy_o=0 immediately. After release, in_ready_o=1.
- Streaming, SKID=1, out_ready_i=1: inject ctrl 9'h1A3 then 9'h0F0 on consecutive cycles -> each appears exactly one cycle later, in order, occupancy_o stays 1.
- Backpressure, SKID=1:
  - Stimulus: hold out_ready_i=0 and send A, B, C.
  - Response: A sits in main, B in skid; occupancy_o=2, in_ready_o=0, so C is held upstream.
  - Then raise out_ready_i: A, B, C emerge on consecutive cycles.
- Flush with FULL state: assert flush_i one cycle -> next cycle occupancy_o=0, out_valid_o=0, out_ctrl_o=0. in_ready_o was 0 during the flush cycle.
- Stall: FULL stage, stall_i high 3 cycles with out_ready_i=1 -> no dequeue, out_ctrl_o=0, in_ready_o=0. After release, entries continue in order, unchanged.
- SKID=0 mode: out_ready_i=0 with main full -> in_ready_o=0. Raising out_ready_i the same cycle -> in_ready_o=1 combinationally; enq and deq occur together and occupancy_o stays 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared ID/EX stage definitions: bundle widths, control field positions,
// the packed control record and the occupancy-derived stage states.
package pipe_pkg;

  localparam int ID_EX_CTRL_W = 9;
  localparam int ID_EX_DATA_W = 128;

  // Bit positions of the control fields inside the control bundle
  localparam int CTRL_ALUOP_LSB  = 0;
  localparam int CTRL_ALUOP_MSB  = 1;
  localparam int CTRL_EXTOP      = 2;
  localparam int CTRL_MEMREAD    = 3;
  localparam int CTRL_MEMWRITE   = 4;
  localparam int CTRL_REGWRITE   = 5;
  localparam int CTRL_MEMTOREG   = 6;
  localparam int CTRL_ALUSRC     = 7;
  localparam int CTRL_REGDST     = 8;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       ext_op;
    logic [1:0] alu_op;
  } id_ex_ctrl_t;

  // Stage state is simply how many entries are held
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with stall, synchronous flush and an
// optional one-entry skid buffer that decouples in_ready_o from out_ready_i.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              enq;
  logic              deq;
  occ_state_e        state;

  // The main entry always drives the outputs; control is masked to NOP when idle
  assign out_valid_o = main_valid & ~stall_i;
  assign out_data_o  = main_data;
  assign out_ctrl_o  = out_valid_o ? main_ctrl : '0;
  assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};

  assign deq = out_valid_o & out_ready_i;
  assign enq = in_valid_i & in_ready_o;

  // Skid mode accepts purely on registered state; single-register mode needs the downstream slot
  if (SKID != 0) begin : g_skid_ready
    assign in_ready_o = ~skid_valid & ~stall_i & ~flush_i;
  end else begin : g_reg_ready
    assign in_ready_o = (~main_valid | out_ready_i) & ~stall_i & ~flush_i;
  end

  // Decode the held-entry count into the stage state
  always_comb begin
    state = EMPTY;
    if (skid_valid) begin
      state = FULL;
    end else if (main_valid) begin
      state = ONE;
    end
  end

  // Entry movement: flush drops everything, stall freezes, otherwise FIFO enq/deq
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!stall_i) begin
      case (state)
        EMPTY: begin
          if (enq) begin
            main_valid <= 1'b1;
            main_data  <= in_data_i;
            main_ctrl  <= in_ctrl_i;
          end
        end
        ONE: begin
          if (enq && deq) begin
            main_data <= in_data_i;
            main_ctrl <= in_ctrl_i;
          end else if (deq) begin
            main_valid <= 1'b0;
          end else if (enq && SKID != 0) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data_i;
            skid_ctrl  <= in_ctrl_i;
          end
        end
        FULL: begin
          if (deq) begin
            main_data  <= skid_data;
            main_ctrl  <= skid_ctrl;
            skid_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
